// File: rtl/reg_access_if.sv
// Register-access bus: the decode, operand, writeback and register-file signal groups.
// master = sequencer side (reg_access_ctrl); slave = the surrounding core.
interface reg_access_if #(
    parameter int REGISTER_WIDTH  = 32,
    parameter int REG_INDEX_WIDTH = 5
);
    logic                       dec_valid;
    logic                       dec_ready;
    logic [REG_INDEX_WIDTH-1:0] dec_rs1;
    logic [REG_INDEX_WIDTH-1:0] dec_rs2;
    logic [REG_INDEX_WIDTH-1:0] dec_rd;
    logic                       dec_rd_wr;

    logic                       op_valid;
    logic                       op_ready;
    logic [REGISTER_WIDTH-1:0]  op_a;
    logic [REGISTER_WIDTH-1:0]  op_b;
    logic [REG_INDEX_WIDTH-1:0] op_rd;
    logic                       op_rd_wr;

    logic                       wb_valid;
    logic                       wb_ready;
    logic [REGISTER_WIDTH-1:0]  wb_data;

    logic [REG_INDEX_WIDTH-1:0] rf_rd_index_1;
    logic [REG_INDEX_WIDTH-1:0] rf_rd_index_2;
    logic [REGISTER_WIDTH-1:0]  reg_data_1;
    logic [REGISTER_WIDTH-1:0]  reg_data_2;
    logic                       rf_wr_en;
    logic [REG_INDEX_WIDTH-1:0] rf_wr_index;
    logic [REGISTER_WIDTH-1:0]  rf_wr_data;

    modport master (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_wr,
        output dec_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_wr,
        input  op_ready,
        input  wb_valid, wb_data,
        output wb_ready,
        output rf_rd_index_1, rf_rd_index_2,
        input  reg_data_1, reg_data_2,
        output rf_wr_en, rf_wr_index, rf_wr_data
    );

    modport slave (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_wr,
        input  dec_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_wr,
        output op_ready,
        output wb_valid, wb_data,
        input  wb_ready,
        input  rf_rd_index_1, rf_rd_index_2,
        output reg_data_1, reg_data_2,
        input  rf_wr_en, rf_wr_index, rf_wr_data
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Operand-fetch / writeback sequencer, one instruction in flight at a time.
// Optional REG_ACCESS_PERF_CNT_EN adds a wb_count output counting register-file writes.
module reg_access_ctrl #(
    parameter int REGISTER_WIDTH  = 32,
    parameter int REG_INDEX_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_access_if.master bus
`ifdef REG_ACCESS_PERF_CNT_EN
    ,
    output logic [31:0] wb_count
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_WB, WRITE} state_t;

    state_t state, state_nxt;

    logic                       dec_ready_q, op_valid_q, wb_ready_q, wr_en_q;
    logic                       dec_ready_nxt, op_valid_nxt, wb_ready_nxt, wr_en_nxt;
    logic [REG_INDEX_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic                       rd_wr_q;
    logic [REGISTER_WIDTH-1:0]  op_a_q, op_b_q, res_q;
    logic                       dec_fire, op_fire, wb_fire;

    assign dec_fire = (state == IDLE) && dec_ready_q && bus.dec_valid;
    assign op_fire  = (state == ISSUE) && bus.op_ready;
    assign wb_fire  = (state == WAIT_WB) && bus.wb_valid;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (dec_fire) state_nxt = FETCH;
            FETCH:   state_nxt = ISSUE;
            ISSUE:   if (op_fire) state_nxt = rd_wr_q ? WAIT_WB : IDLE;
            WAIT_WB: if (wb_fire) state_nxt = (rd_q != '0) ? WRITE : IDLE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Handshake flags are decoded from the next state so they come straight out of flops.
        dec_ready_nxt = (state_nxt == IDLE);
        op_valid_nxt  = (state_nxt == ISSUE);
        wb_ready_nxt  = (state_nxt == WAIT_WB);
        wr_en_nxt     = (state_nxt == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dec_ready_q <= 1'b0;
            op_valid_q  <= 1'b0;
            wb_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            dec_ready_q <= dec_ready_nxt;
            op_valid_q  <= op_valid_nxt;
            wb_ready_q  <= wb_ready_nxt;
            wr_en_q     <= wr_en_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd_wr_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            if (dec_fire) begin
                rs1_q   <= bus.dec_rs1;
                rs2_q   <= bus.dec_rs2;
                rd_q    <= bus.dec_rd;
                rd_wr_q <= bus.dec_rd_wr;
            end
            if (state == FETCH) begin
                op_a_q <= bus.reg_data_1;
                op_b_q <= bus.reg_data_2;
            end
            if (wb_fire) res_q <= bus.wb_data;
        end
    end

`ifdef REG_ACCESS_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wb_count <= '0;
        else if (wr_en_q) wb_count <= wb_count + 32'd1;
    end
`endif

    assign bus.dec_ready     = dec_ready_q;
    assign bus.op_valid      = op_valid_q;
    assign bus.op_a          = op_a_q;
    assign bus.op_b          = op_b_q;
    assign bus.op_rd         = rd_q;
    assign bus.op_rd_wr      = rd_wr_q;
    assign bus.wb_ready      = wb_ready_q;
    // Indices and write data are forced to zero outside their own state.
    assign bus.rf_rd_index_1 = (state == FETCH) ? rs1_q : '0;
    assign bus.rf_rd_index_2 = (state == FETCH) ? rs2_q : '0;
    assign bus.rf_wr_en      = wr_en_q;
    assign bus.rf_wr_index   = wr_en_q ? rd_q : '0;
    assign bus.rf_wr_data    = wr_en_q ? res_q : '0;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: register-file model, directed vector table,
// randomized instructions against a spec-level reference, reset-mid-op sequences.
module tb_reg_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_access_if #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5)) rif ();

`ifdef REG_ACCESS_PERF_CNT_EN
    logic [31:0] wb_count;
`endif

    reg_access_ctrl #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(rif.master)
`ifdef REG_ACCESS_PERF_CNT_EN
        ,
        .wb_count(wb_count)
`endif
    );

    // Register file seen by the DUT: combinational reads, x0 hardwired to 0.
    logic [31:0] rf_mem [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          wr_seen = 0;

    always @(posedge clk) begin
        if (pl_en) rf_mem[pl_idx] <= pl_val;
        else if (rif.rf_wr_en) begin
            rf_mem[rif.rf_wr_index] <= rif.rf_wr_data;
            wr_seen <= wr_seen + 1;
        end
    end

    assign rif.reg_data_1 = (rif.rf_rd_index_1 == 5'd0) ? 32'd0 : rf_mem[rif.rf_rd_index_1];
    assign rif.reg_data_2 = (rif.rf_rd_index_2 == 5'd0) ? 32'd0 : rf_mem[rif.rf_rd_index_2];

    // Reference model: architectural register contents and expected write count.
    logic [31:0] ref_mem [32];
    int          exp_writes = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rd_wr;
        logic [31:0] wb;
        int          op_wait, wb_wait;
        logic [31:0] exp_a, exp_b;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rif.dec_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dec_ready_wait", 32'(rif.dec_ready), 32'd1);
    endtask

    task automatic run_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic rd_wr, input logic [31:0] wb, input int op_wait,
                             input int wb_wait, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input logic exp_wr);
        wait_ready();
        rif.dec_valid = 1'b1;
        rif.dec_rs1 = rs1;  rif.dec_rs2 = rs2;
        rif.dec_rd = rd;    rif.dec_rd_wr = rd_wr;
        @(negedge clk);                                  // FETCH
        rif.dec_valid = 1'b0;
        check("fetch_idx1", 32'(rif.rf_rd_index_1), 32'(rs1));
        check("fetch_idx2", 32'(rif.rf_rd_index_2), 32'(rs2));
        check("fetch_opv", 32'(rif.op_valid), 32'd0);
        check("fetch_decrdy", 32'(rif.dec_ready), 32'd0);
        @(negedge clk);                                  // ISSUE
        check("issue_opv", 32'(rif.op_valid), 32'd1);
        check("issue_op_a", rif.op_a, exp_a);
        check("issue_op_b", rif.op_b, exp_b);
        check("issue_op_rd", 32'(rif.op_rd), 32'(rd));
        check("issue_op_rdwr", 32'(rif.op_rd_wr), 32'(rd_wr));
        check("issue_idx1", 32'(rif.rf_rd_index_1), 32'd0);
        if (op_wait > 0) begin
            // Traffic on the other handshakes while busy must be ignored.
            rif.dec_valid = 1'b1;
            rif.dec_rs1 = 5'd31;
            rif.wb_valid = 1'b1;
            rif.wb_data = 32'hBAD0BAD0;
        end
        for (int i = 0; i < op_wait; i++) begin
            @(negedge clk);
            check("bp_opv", 32'(rif.op_valid), 32'd1);
            check("bp_op_a", rif.op_a, exp_a);
            check("bp_op_b", rif.op_b, exp_b);
            check("bp_op_rd", 32'(rif.op_rd), 32'(rd));
            check("bp_decrdy", 32'(rif.dec_ready), 32'd0);
            check("bp_wbrdy", 32'(rif.wb_ready), 32'd0);
        end
        rif.dec_valid = 1'b0;
        rif.wb_valid = 1'b0;
        rif.op_ready = 1'b1;
        @(negedge clk);
        rif.op_ready = 1'b0;
        check("post_op_opv", 32'(rif.op_valid), 32'd0);
        check("post_op_wren", 32'(rif.rf_wr_en), 32'd0);
        if (!rd_wr) begin
            check("nowb_decrdy", 32'(rif.dec_ready), 32'd1);
            check("nowb_wbrdy", 32'(rif.wb_ready), 32'd0);
        end else begin
            check("wait_wbrdy", 32'(rif.wb_ready), 32'd1);
            for (int i = 0; i < wb_wait; i++) begin
                @(negedge clk);
                check("wbwait_wbrdy", 32'(rif.wb_ready), 32'd1);
                check("wbwait_decrdy", 32'(rif.dec_ready), 32'd0);
                check("wbwait_wren", 32'(rif.rf_wr_en), 32'd0);
            end
            rif.wb_valid = 1'b1;
            rif.wb_data = wb;
            @(negedge clk);
            rif.wb_valid = 1'b0;
            rif.wb_data = $urandom;
            check("wb_wren", 32'(rif.rf_wr_en), 32'(exp_wr));
            check("wb_wbrdy", 32'(rif.wb_ready), 32'd0);
            if (exp_wr) begin
                check("wb_idx", 32'(rif.rf_wr_index), 32'(rd));
                check("wb_data", rif.rf_wr_data, wb);
                check("wb_decrdy", 32'(rif.dec_ready), 32'd0);
                @(negedge clk);
                check("after_wr_wren", 32'(rif.rf_wr_en), 32'd0);
                check("after_wr_idx", 32'(rif.rf_wr_index), 32'd0);
                check("after_wr_decrdy", 32'(rif.dec_ready), 32'd1);
            end else begin
                check("x0_decrdy", 32'(rif.dec_ready), 32'd1);
            end
        end
        if (rd_wr && rd != 5'd0) begin
            ref_mem[rd] = wb;
            exp_writes++;
        end
    endtask

    task automatic reset_mid_op(input bit in_write);
        int w0;
        wait_ready();
        rif.dec_valid = 1'b1;
        rif.dec_rs1 = 5'd1;  rif.dec_rs2 = 5'd2;
        rif.dec_rd = 5'd7;   rif.dec_rd_wr = 1'b1;
        @(negedge clk);
        rif.dec_valid = 1'b0;
        @(negedge clk);
        rif.op_ready = 1'b1;
        @(negedge clk);
        rif.op_ready = 1'b0;
        check("rst_wait_wbrdy", 32'(rif.wb_ready), 32'd1);
        if (in_write) begin
            rif.wb_valid = 1'b1;
            rif.wb_data = 32'hFEEDF00D;
            @(negedge clk);
            rif.wb_valid = 1'b0;
            check("rst_write_wren", 32'(rif.rf_wr_en), 32'd1);
        end
        w0 = wr_seen;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wren", 32'(rif.rf_wr_en), 32'd0);
        check("rst_mid_wridx", 32'(rif.rf_wr_index), 32'd0);
        check("rst_mid_wrdata", rif.rf_wr_data, 32'd0);
        check("rst_mid_wbrdy", 32'(rif.wb_ready), 32'd0);
        check("rst_mid_decrdy", 32'(rif.dec_ready), 32'd0);
        check("rst_mid_oprd", 32'(rif.op_rd), 32'd0);
        check("rst_mid_oprdwr", 32'(rif.op_rd_wr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_release_decrdy", 32'(rif.dec_ready), 32'd1);
        check("rst_mid_no_write", 32'(wr_seen - w0), 32'd0);
        check("rst_mid_x7", rf_mem[7], ref_mem[7]);
        run_instr(5'd7, 5'd0, 5'd0, 1'b0, 32'd0, 0, 0, ref_mem[7], 32'd0, 1'b0);
    endtask

    initial begin
        int w0;
        logic [4:0]  r1, r2, rd;
        logic        rw;
        logic [31:0] d;

        rif.dec_valid = 1'b0; rif.dec_rs1 = '0; rif.dec_rs2 = '0;
        rif.dec_rd = '0;      rif.dec_rd_wr = 1'b0;
        rif.op_ready = 1'b0;  rif.wb_valid = 1'b0; rif.wb_data = '0;

        vecs[0] = '{5'd10, 5'd15, 5'd3, 1'b0, 32'd0,        0, 0, 32'hAAAA0001, 32'h5555000F, 1'b0};
        vecs[1] = '{5'd10, 5'd0,  5'd5, 1'b1, 32'd1234,     0, 0, 32'hAAAA0001, 32'd0,        1'b1};
        vecs[2] = '{5'd5,  5'd5,  5'd0, 1'b0, 32'd0,        0, 0, 32'd1234,     32'd1234,     1'b0};
        vecs[3] = '{5'd0,  5'd10, 5'd0, 1'b1, 32'd2431,     0, 0, 32'd0,        32'hAAAA0001, 1'b0};
        vecs[4] = '{5'd0,  5'd0,  5'd4, 1'b0, 32'd0,        0, 0, 32'd0,        32'd0,        1'b0};
        vecs[5] = '{5'd15, 5'd5,  5'd9, 1'b1, 32'hDEADBEEF, 4, 3, 32'h5555000F, 32'd1234,     1'b1};
        vecs[6] = '{5'd9,  5'd10, 5'd1, 1'b0, 32'd0,        0, 0, 32'hDEADBEEF, 32'hAAAA0001, 1'b0};

        // Preload the register file while reset is held.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pl_en  = 1'b1;
            pl_idx = 5'(i);
            pl_val = (i == 0) ? 32'd0 : (i == 10) ? 32'hAAAA0001 :
                     (i == 15) ? 32'h5555000F : $urandom;
            ref_mem[i] = pl_val;
        end
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("rst_decrdy", 32'(rif.dec_ready), 32'd0);
        check("rst_opv", 32'(rif.op_valid), 32'd0);
        check("rst_wbrdy", 32'(rif.wb_ready), 32'd0);
        check("rst_wren", 32'(rif.rf_wr_en), 32'd0);
        check("rst_op_a", rif.op_a, 32'd0);
        check("rst_op_b", rif.op_b, 32'd0);
        check("rst_op_rd", 32'(rif.op_rd), 32'd0);
        check("rst_op_rdwr", 32'(rif.op_rd_wr), 32'd0);
        check("rst_idx1", 32'(rif.rf_rd_index_1), 32'd0);
        check("rst_idx2", 32'(rif.rf_rd_index_2), 32'd0);
        check("rst_wridx", 32'(rif.rf_wr_index), 32'd0);
        check("rst_wrdata", rif.rf_wr_data, 32'd0);
`ifdef REG_ACCESS_PERF_CNT_EN
        check("rst_wb_count", wb_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("release_decrdy", 32'(rif.dec_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            w0 = wr_seen;
            run_instr(vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].rd_wr, vecs[v].wb,
                      vecs[v].op_wait, vecs[v].wb_wait, vecs[v].exp_a, vecs[v].exp_b,
                      vecs[v].exp_wr);
            check("vec_write_count", 32'(wr_seen - w0), 32'(vecs[v].exp_wr));
`ifdef REG_ACCESS_PERF_CNT_EN
            check("vec_wb_count", wb_count, 32'(exp_writes));
`endif
        end
        check("x0_stays_zero", rf_mem[0], 32'd0);

        reset_mid_op(1'b0);
        reset_mid_op(1'b1);

        for (int n = 0; n < 40; n++) begin
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            if (n % 8 == 0) rd = 5'd0;
            rw = 1'($urandom_range(0, 1));
            d  = $urandom;
            run_instr(r1, r2, rd, rw, d, $urandom_range(0, 2), $urandom_range(0, 2),
                      ref_mem[r1], ref_mem[r2], rw && (rd != 5'd0));
        end

        @(negedge clk);
        check("total_writes", 32'(wr_seen), 32'(exp_writes));
        for (int i = 0; i < 32; i++) check("final_reg", rf_mem[i], ref_mem[i]);
`ifdef REG_ACCESS_PERF_CNT_EN
        check("final_wb_count", wb_count, 32'(exp_writes));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Operand-fetch and writeback sequencer for the multi-cycle core; the initiator side of the register-file interface. Accepts one decoded instruction at a time and drives the two read indices, then captures both operands and hands them to execute. It then takes the execute result and issues the single-cycle write pulse into the register file. One instruction is in flight at a time, so no hazard or bypass logic is needed.

## Interface
- REGISTER_WIDTH, 32, data width of operands and results
- REG_INDEX_WIDTH, 5, register index width (32 registers)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- dec_valid / dec_ready  in / out  1  decode handshake
- dec_rs1, dec_rs2, dec_rd  in  REG_INDEX_WIDTH  source and destination indices
- dec_rd_wr  in  1  instruction writes rd
- op_valid / op_ready  out / in  1  operand handshake to execute
- op_a, op_b  out  REGISTER_WIDTH  captured operands
- op_rd  out  REG_INDEX_WIDTH  destination index forwarded to execute
- op_rd_wr  out  1  forwarded write flag
- wb_valid / wb_ready  in / out  1  result handshake from execute
- wb_data  in  REGISTER_WIDTH  result
- rf_rd_index_1, rf_rd_index_2  out  REG_INDEX_WIDTH  register-file read indices; register-file reads are combinational
- reg_data_1, reg_data_2  in  REGISTER_WIDTH  register-file read data
- rf_wr_en  out  1  register-file write strobe
- rf_wr_index  out  REG_INDEX_WIDTH  register-file write index
- rf_wr_data  out  REGISTER_WIDTH  register-file write data

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_WB, WRITE.
- **IDLE**
  - dec_ready=1.
  - On dec_valid, latch rs1/rs2/rd/rd_wr and go to FETCH.
- **FETCH**
  - rf_rd_index_1/2 are driven from the latched rs1/rs2.
  - At the end of this cycle, capture reg_data_1/2 into op_a/op_b and go to ISSUE.
- **ISSUE**
  - op_valid=1; op_a, op_b, op_rd and op_rd_wr are held stable until op_ready.
  - On the handshake: if rd_wr=0, go to IDLE; otherwise go to WAIT_WB.
- **WAIT_WB**
  - wb_ready=1.
  - On wb_valid, latch wb_data.
  - If rd≠0, go to WRITE; if rd==0, go to IDLE and discard the result (no write).
- **WRITE**
  - rf_wr_en=1 for exactly one cycle, with rf_wr_index=rd and rf_wr_data=latched result.
  - Then go to IDLE.
- rf_rd_index_1/2 read 0 in every state except FETCH.
- rf_wr_index and rf_wr_data read 0 in every state except WRITE.
- dec_valid outside IDLE is ignored; dec_ready=0 there.
- wb_valid outside WAIT_WB is ignored; no result is buffered.
- Source index 0 needs no special case: the register file returns 0.

## Timing
- Reset values (all outputs): dec_ready=0, op_valid=0, wb_ready=0, rf_wr_en=0, and every data and index output 0.
- dec_ready rises in the first cycle after rst_n deasserts.
- Latency, with the decode handshake at edge N:
  - FETCH occupies cycle N+1.
  - op_valid is high from cycle N+2.
  - If op_ready is already high, the op handshake completes at the end of N+2.
  - With a wb handshake at edge M, rf_wr_en is high during cycle M+1.
  - The next decode can be accepted in cycle M+2.
- Minimum period: 3 cycles without writeback, 5 cycles with writeback (zero-wait execute).
- State transitions, handshake flags and rf_wr_en are registered; none of them depends combinationally on dec_valid, op_ready or wb_valid.
- Reset asserted mid-operation: asynchronous return to IDLE.
  - A pending write is dropped; rf_wr_en must fall immediately with rst_n.
  - All latched fields clear.

## Configuration
- REG_ACCESS_PERF_CNT_EN
  - **Defined:** adds output port `wb_count [31:0]`.
    - Resets to 0.
    - Increments by 1 on each cycle with rf_wr_en=1.
    - Wraps from 0xFFFFFFFF to 0.
    - Discarded rd==0 results are not counted.
  - **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles → all outputs 0; dec_ready=1 in the first cycle after release.
- **Read path:** preload x10=0xAAAA0001 and x15=0x5555000F; decode rs1=10, rs2=15, rd_wr=0 → op_valid at N+2 with op_a=0xAAAA0001 and op_b=0x5555000F; return to IDLE on the op handshake with no rf_wr_en.
- **Writeback:** decode rd=5, rd_wr=1; then wb_data=1234 → one-cycle rf_wr_en with index 5 and data 1234; a following read of x5 returns 1234.
- **x0 write:** decode rd=0, rd_wr=1; wb_data=2431 → wb handshake completes, rf_wr_en never asserts, x0 reads 0 (counter stays 0 when enabled).
- **Backpressure:** op_ready held low for 4 cycles, then wb_valid delayed 3 cycles → op_* stable throughout, dec_ready=0 throughout, and exactly one write.
- **Reset mid-op:** drop rst_n in WAIT_WB and again in WRITE → immediate IDLE, rf_wr_en=0, and the target register is unchanged.
